// File: rtl/light_level_ctrl.sv
// Rotary-encoder driven lamp level controller: per-channel 8-bit levels, channel select,
// and a valid/ready update port to a PWM bank. Optional acceleration: LIGHT_LEVEL_CTRL_ACCEL_EN.

module light_level_lane (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       wr_en,
  input  logic [7:0] wr_level,
  output logic [7:0] level
);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   level <= '0;
    else if (wr_en) level <= wr_level;
  end
endmodule

module light_level_ctrl #(
  parameter int CLOCK_FREQ_MHZ  = 100,
  parameter int CHANNELS        = 4,
  parameter int STEP            = 8,
  parameter int ACCEL_WINDOW_US = 20000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    left_i,
  input  logic                    right_i,
  input  logic                    btn_i,
  output logic [2:0]              sel_o,
  output logic [CHANNELS*8-1:0]   levels_o,
  output logic                    upd_valid_o,
  output logic [2:0]              upd_ch_o,
  output logic [7:0]              upd_level_o,
  input  logic                    upd_ready_i
);

  typedef enum logic [1:0] {IDLE, APPLY, SEND} state_t;

  localparam logic [8:0]  STEP_1     = 9'(STEP);
  localparam logic [8:0]  STEP_4     = 9'(STEP * 4);
  localparam logic [31:0] ACC_WINDOW = 32'(CLOCK_FREQ_MHZ * ACCEL_WINDOW_US);

  state_t state_q, state_d;

  // Inputs are registered once; all decisions below use the registered pulses.
  logic left_q, right_q, btn_q;
  logic rot_vld, rot_dir;

  logic [2:0] sel_q, sel_nxt;
  logic       job_dir_q, job_x4_q;
  logic [2:0] job_ch_q;
  logic       pend_vld_q, pend_dir_q, pend_vld_d, pend_dir_d;
  logic       ev_vld, ev_dir, job_load, accel_hit;
  logic [2:0] upd_ch_q;
  logic [7:0] upd_level_q;

  logic [CHANNELS-1:0][7:0] lvl;
  logic [CHANNELS-1:0]      lane_we;
  logic [7:0] old_lvl, new_lvl;
  logic [8:0] step9, sum9, dif9;
  logic       wr_en;

  assign rot_vld = left_q ^ right_q;
  assign rot_dir = right_q;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_lane
      assign lane_we[k] = wr_en && (job_ch_q == 3'(k));
      light_level_lane u_lane (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .wr_en    (lane_we[k]),
        .wr_level (new_lvl),
        .level    (lvl[k])
      );
      assign levels_o[8*k +: 8] = lvl[k];
    end
  endgenerate

  always_comb begin
    old_lvl = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (job_ch_q == 3'(i)) old_lvl = lvl[i];
  end

  // 9-bit arithmetic: bit 8 flags overflow (up) or borrow (down).
  assign step9   = job_x4_q ? STEP_4 : STEP_1;
  assign sum9    = {1'b0, old_lvl} + step9;
  assign dif9    = {1'b0, old_lvl} - step9;
  assign new_lvl = job_dir_q ? (sum9[8] ? 8'hFF : sum9[7:0])
                             : (dif9[8] ? 8'h00 : dif9[7:0]);
  assign wr_en   = (state_q == APPLY) && (new_lvl != old_lvl);

  assign sel_nxt = (sel_q == 3'(CHANNELS - 1)) ? 3'd0 : sel_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    ev_vld     = 1'b0;
    ev_dir     = rot_dir;
    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          // Pending job goes first; a fresh pulse takes its slot.
          ev_vld     = 1'b1;
          ev_dir     = pend_dir_q;
          pend_vld_d = rot_vld;
          pend_dir_d = rot_dir;
        end else begin
          ev_vld = rot_vld;
        end
        if (ev_vld) state_d = APPLY;
      end
      APPLY, SEND: begin
        if (rot_vld) begin
          if (pend_vld_q && (pend_dir_q != rot_dir)) begin
            pend_vld_d = 1'b0;
          end else begin
            pend_vld_d = 1'b1;
            pend_dir_d = rot_dir;
          end
        end
        if (state_q == APPLY)  state_d = wr_en ? SEND : IDLE;
        else if (upd_ready_i)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign job_load = (state_q == IDLE) && ev_vld;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      btn_q       <= 1'b0;
      sel_q       <= '0;
      job_dir_q   <= 1'b0;
      job_x4_q    <= 1'b0;
      job_ch_q    <= '0;
      pend_vld_q  <= 1'b0;
      pend_dir_q  <= 1'b0;
      upd_ch_q    <= '0;
      upd_level_q <= '0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_i;
      right_q    <= right_i;
      btn_q      <= btn_i;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      if (btn_q) sel_q <= sel_nxt;
      // Job captures sel_q before any same-cycle increment lands.
      if (job_load) begin
        job_dir_q <= ev_dir;
        job_ch_q  <= sel_q;
        job_x4_q  <= accel_hit;
      end
      if (wr_en) begin
        upd_ch_q    <= job_ch_q;
        upd_level_q <= new_lvl;
      end
    end
  end

`ifdef LIGHT_LEVEL_CTRL_ACCEL_EN
  logic [31:0] acc_cnt_q;
  logic        acc_prev_vld_q, acc_prev_dir_q;

  assign accel_hit = acc_prev_vld_q && (acc_prev_dir_q == ev_dir) && (acc_cnt_q < ACC_WINDOW);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_cnt_q      <= '0;
      acc_prev_vld_q <= 1'b0;
      acc_prev_dir_q <= 1'b0;
    end else if (job_load) begin
      acc_cnt_q      <= '0;
      acc_prev_vld_q <= 1'b1;
      acc_prev_dir_q <= ev_dir;
    end else if (acc_cnt_q != '1) begin
      acc_cnt_q <= acc_cnt_q + 32'd1;
    end
  end
`else
  logic unused_accel_cfg;
  assign accel_hit        = 1'b0;
  assign unused_accel_cfg = ^ACC_WINDOW;
`endif

  assign sel_o       = sel_q;
  assign upd_valid_o = (state_q == SEND);
  assign upd_ch_o    = upd_ch_q;
  assign upd_level_o = upd_level_q;

endmodule

// File: tb/tb_light_level_ctrl.sv
// Bench for light_level_ctrl: directed scenarios plus randomized rotations checked
// against a behavioural level model (saturating arithmetic, channel wrap, acceleration window).
module tb_light_level_ctrl;
  localparam int CH     = 4;
  localparam int STEP   = 8;
  localparam int MHZ    = 1;
  localparam int WIN_US = 2000;
  localparam int WIN    = MHZ * WIN_US;
`ifdef LIGHT_LEVEL_CTRL_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic left = 1'b0, right = 1'b0, btn = 1'b0, ready = 1'b1;
  logic [2:0]      sel, uch;
  logic [CH*8-1:0] levels;
  logic            vld;
  logic [7:0]      ulvl;

  light_level_ctrl #(.CLOCK_FREQ_MHZ(MHZ), .CHANNELS(CH), .STEP(STEP), .ACCEL_WINDOW_US(WIN_US)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .left_i(left), .right_i(right), .btn_i(btn),
    .sel_o(sel), .levels_o(levels), .upd_valid_o(vld), .upd_ch_o(uch),
    .upd_level_o(ulvl), .upd_ready_i(ready));

  always #5 clk = ~clk;

  int     checks = 0, failures = 0;
  longint cyc_cnt = 0;
  int     hs_q[$];
  int     mdl_lvl[CH];
  int     mdl_sel;
  bit     prev_vld, prev_dir;
  longint prev_cyc;
  bit     exp_hs;
  int     exp_ch, exp_lvl;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Handshake seen at negedge completes at the following posedge.
  always @(negedge clk) if (rst_n && vld && ready) hs_q.push_back(int'(uch) * 256 + int'(ulvl));

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) mdl_lvl[i] = 0;
    mdl_sel = 0; prev_vld = 0; prev_dir = 0; prev_cyc = 0;
  endtask

  task automatic model_rot(input bit dir, input longint scyc);
    int st, old, nw;
    st = STEP;
    if (ACCEL && prev_vld && prev_dir == dir && (scyc - prev_cyc) <= WIN) st = STEP * 4;
    prev_vld = 1; prev_dir = dir; prev_cyc = scyc;
    old = mdl_lvl[mdl_sel];
    nw  = dir ? old + st : old - st;
    if (nw > 255) nw = 255;
    if (nw < 0) nw = 0;
    exp_hs = (nw != old); exp_ch = mdl_sel; exp_lvl = nw;
    mdl_lvl[mdl_sel] = nw;
  endtask

  function automatic logic [CH*8-1:0] mdl_levels();
    logic [CH*8-1:0] e;
    for (int i = 0; i < CH; i++) e[i*8 +: 8] = 8'(mdl_lvl[i]);
    return e;
  endfunction

  task automatic drive_rot(input bit dir, input bit b, input int dly);
    ready = (dly == 0);
    if (dir) right = 1'b1; else left = 1'b1;
    btn = b;
    cyc(1);
    right = 1'b0; left = 1'b0; btn = 1'b0;
    model_rot(dir, cyc_cnt);
    if (b) mdl_sel = (mdl_sel + 1) % CH;
    if (dly > 0) begin cyc(dly); ready = 1'b1; end
    cyc(6);
  endtask

  task automatic drive_btn();
    btn = 1'b1; cyc(1); btn = 1'b0; cyc(1);
    mdl_sel = (mdl_sel + 1) % CH;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!vld && n < 20) begin cyc(1); n++; end
    checks++;
    if (!vld) begin failures++; $display("FAIL %s valid_timeout got=0 exp=1", nm); end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (sel !== 3'd0)   begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (levels !== '0)  begin failures++; $display("FAIL reset_levels got=%h exp=0", levels); end
    checks++; if (vld !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", vld); end
    checks++; if (uch !== 3'd0)   begin failures++; $display("FAIL reset_ch got=%0d exp=0", uch); end
    checks++; if (ulvl !== 8'd0)  begin failures++; $display("FAIL reset_level got=%0d exp=0", ulvl); end
    cyc(2);
    model_reset(); hs_q.delete();
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic();
    hs_q.delete(); ready = 1'b1;
    right = 1'b1; cyc(1); right = 1'b0;
    model_rot(1'b1, cyc_cnt);
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL basic_lat_n got=%b exp=0", vld); end
    cyc(1);
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL basic_lat_n1 got=%b exp=0", vld); end
    cyc(1);
    checks++; if (vld !== 1'b1) begin failures++; $display("FAIL basic_lat_n2 got=%b exp=1", vld); end
    checks++; if (uch !== 3'd0) begin failures++; $display("FAIL basic_ch got=%0d exp=0", uch); end
    checks++; if (ulvl !== 8'd8) begin failures++; $display("FAIL basic_level got=%0d exp=8", ulvl); end
    checks++; if (levels[7:0] !== 8'd8) begin failures++; $display("FAIL basic_levels0 got=%0d exp=8", levels[7:0]); end
    cyc(1);
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", vld); end
    cyc(3);
    checks++; if (hs_q.size() != 1) begin failures++; $display("FAIL basic_hs_count got=%0d exp=1", hs_q.size()); end
  endtask

  task automatic test_saturation();
    int n = 0, last = -1;
    hs_q.delete();
    while (mdl_lvl[0] != 255 && n < 64) begin drive_rot(1'b1, 1'b0, 0); n++; end
    if (hs_q.size() > 0) last = hs_q[$];
    checks++; if (hs_q.size() != n) begin failures++; $display("FAIL sat_hs_count got=%0d exp=%0d", hs_q.size(), n); end
    checks++; if (last != 255) begin failures++; $display("FAIL sat_last got=%0d exp=255", last); end
    hs_q.delete();
    drive_rot(1'b1, 1'b0, 0);
    checks++; if (hs_q.size() != 0) begin failures++; $display("FAIL sat_no_upd got=%0d exp=0", hs_q.size()); end
    checks++; if (levels[7:0] !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", levels[7:0]); end
    right = 1'b1; left = 1'b1; cyc(1); right = 1'b0; left = 1'b0; cyc(6);
    checks++; if (hs_q.size() != 0) begin failures++; $display("FAIL both_ignored got=%0d exp=0", hs_q.size()); end
    checks++; if (levels !== mdl_levels()) begin failures++; $display("FAIL both_levels got=%h exp=%h", levels, mdl_levels()); end
  endtask

  task automatic test_btn();
    logic [2:0] exp_sel[4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 4; i++) begin
      drive_btn();
      checks++; if (sel !== exp_sel[i]) begin failures++; $display("FAIL btn_wrap got=%0d exp=%0d", sel, exp_sel[i]); end
    end
    drive_btn();
    hs_q.delete();
    drive_rot(1'b1, 1'b1, 0);
    checks++; if (hs_q.size() != 1 || hs_q[0] != exp_ch * 256 + exp_lvl || exp_ch != 1) begin
      failures++; $display("FAIL btn_rot_ch got=%0d entries exp_ch=1 exp_lvl=%0d", hs_q.size(), exp_lvl); end
    checks++; if (sel !== 3'd2) begin failures++; $display("FAIL btn_rot_sel got=%0d exp=2", sel); end
  endtask

  task automatic test_sat_low();
    hs_q.delete();
    drive_rot(1'b0, 1'b0, 0);
    checks++; if (hs_q.size() != 0) begin failures++; $display("FAIL low_no_upd got=%0d exp=0", hs_q.size()); end
    checks++; if (levels[23:16] !== 8'd0) begin failures++; $display("FAIL low_hold got=%0d exp=0", levels[23:16]); end
  endtask

  task automatic test_pending();
    int e1;
    hs_q.delete(); ready = 1'b0;
    right = 1'b1; cyc(1); right = 1'b0;
    model_rot(1'b1, cyc_cnt);
    wait_valid("pend_wait");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (vld !== 1'b1 || uch !== 3'(exp_ch) || ulvl !== 8'(exp_lvl)) begin
        failures++; $display("FAIL hold_stable got=%b/%0d/%0d exp=1/%0d/%0d", vld, uch, ulvl, exp_ch, exp_lvl); end
      if (i == 2) right = 1'b1;
      if (i == 3) right = 1'b0;
      if (i == 5) left = 1'b1;
      if (i == 6) left = 1'b0;
      cyc(1);
    end
    ready = 1'b1; cyc(10);
    checks++; if (hs_q.size() != 1) begin failures++; $display("FAIL pend_cleared got=%0d exp=1", hs_q.size()); end
    checks++; if (levels !== mdl_levels()) begin failures++; $display("FAIL pend_levels got=%h exp=%h", levels, mdl_levels()); end
    hs_q.delete(); ready = 1'b0;
    right = 1'b1; cyc(1); right = 1'b0;
    model_rot(1'b1, cyc_cnt);
    e1 = exp_ch * 256 + exp_lvl;
    wait_valid("pend2_wait");
    right = 1'b1; cyc(1); right = 1'b0; cyc(2);
    ready = 1'b1; cyc(10);
    model_rot(1'b1, cyc_cnt);
    checks++; if (hs_q.size() != 2 || hs_q[0] != e1 || hs_q[1] != exp_ch * 256 + exp_lvl) begin
      failures++; $display("FAIL pend_consume got=%0d entries exp=2 last_exp=%0d", hs_q.size(), exp_lvl); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int op  = $urandom_range(0, 4);
      int dly = $urandom_range(0, 4);
      hs_q.delete();
      if (op == 2) drive_btn();
      else drive_rot(op == 1 || op == 3, op >= 3, dly);
      if (op != 2) begin
        checks++;
        if (hs_q.size() != int'(exp_hs) || (exp_hs && hs_q[0] != exp_ch * 256 + exp_lvl)) begin
          failures++; $display("FAIL rand_upd it=%0d got_n=%0d exp_n=%0d exp=%0d/%0d", it, hs_q.size(), exp_hs, exp_ch, exp_lvl); end
      end
      checks++; if (levels !== mdl_levels()) begin failures++; $display("FAIL rand_levels it=%0d got=%h exp=%h", it, levels, mdl_levels()); end
      checks++; if (sel !== 3'(mdl_sel)) begin failures++; $display("FAIL rand_sel it=%0d got=%0d exp=%0d", it, sel, mdl_sel); end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; left = 1'b0; right = 1'b0; btn = 1'b0; ready = 1'b1;
    cyc(2);
    model_reset(); hs_q.delete();
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_accel();
    int exp2;
    do_reset();
    drive_rot(1'b1, 1'b0, 0);
    cyc(990);
    drive_rot(1'b1, 1'b0, 0);
    exp2 = ACCEL ? 40 : 16;
    checks++; if (hs_q.size() != 2 || hs_q[0] != 8 || hs_q[1] != exp2) begin
      failures++; $display("FAIL accel_short got_n=%0d exp=8,%0d", hs_q.size(), exp2); end
    do_reset();
    drive_rot(1'b1, 1'b0, 0);
    cyc(3000);
    drive_rot(1'b1, 1'b0, 0);
    checks++; if (hs_q.size() != 2 || hs_q[0] != 8 || hs_q[1] != 16) begin
      failures++; $display("FAIL accel_long got_n=%0d exp=8,16", hs_q.size()); end
  endtask

  task automatic test_reset_mid_send();
    ready = 1'b0;
    right = 1'b1; cyc(1); right = 1'b0;
    wait_valid("rst_wait");
    #1 rst_n = 1'b0;
    #1;
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rst_send_valid got=%b exp=0", vld); end
    checks++; if (levels !== '0) begin failures++; $display("FAIL rst_send_levels got=%h exp=0", levels); end
    checks++; if (sel !== 3'd0 || uch !== 3'd0 || ulvl !== 8'd0) begin
      failures++; $display("FAIL rst_send_outs got=%0d/%0d/%0d exp=0/0/0", sel, uch, ulvl); end
    cyc(2);
    model_reset(); hs_q.delete(); ready = 1'b1;
    rst_n = 1'b1;
    cyc(1);
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_btn();
    test_sat_low();
    test_pending();
    test_random();
    test_accel();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
